// File: rtl/cache_pkg.sv
// Shared cache-fill definitions: controller state encoding and block geometry,
// used by the fill controller and by the cache tag/data arrays.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam int WORDS_PER_BLOCK = 8;
  // Byte offset within a block: word index bits plus the byte-in-word bit.
  localparam int OFFSET_BITS     = $clog2(WORDS_PER_BLOCK) + 1;

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear and enable; done is high once
// the count has reached LIMIT, and the count then holds there.
module fill_counter #(
  parameter int LIMIT = 8,
  parameter int WIDTH = $clog2(LIMIT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !done) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == WIDTH'(LIMIT));

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: issues one pipelined memory read per block word,
// streams returned words into the data array and writes the tag on the last one.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  output logic                               fsm_busy,
  output logic                               memory_enable,
  output logic [ADDR_WIDTH-1:0]              memory_address,
  input  logic                               memory_data_valid,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_index,
  output logic                               write_tag_array
);

  import cache_pkg::*;

  localparam int IDX_BITS          = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_BITS          = IDX_BITS + 1;
  localparam int BLOCK_OFFSET_BITS = IDX_BITS + 1;
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << BLOCK_OFFSET_BITS) - 1);

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  logic                issue_clear, issue_en, issue_done;
  logic                return_clear, return_en, return_done;
  logic [CNT_BITS-1:0] issue_cnt, return_cnt;

  fill_counter #(.LIMIT(WORDS_PER_BLOCK), .WIDTH(CNT_BITS)) u_issue_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (issue_clear),
    .enable (issue_en),
    .count  (issue_cnt),
    .done   (issue_done)
  );

  fill_counter #(.LIMIT(WORDS_PER_BLOCK), .WIDTH(CNT_BITS)) u_return_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (return_clear),
    .enable (return_en),
    .count  (return_cnt),
    .done   (return_done)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    issue_clear      = 1'b0;
    issue_en         = 1'b0;
    return_clear     = 1'b0;
    return_en        = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d       = miss_address & ~OFFSET_MASK;
          issue_clear  = 1'b1;
          return_clear = 1'b1;
          state_d      = FILL;
        end
      end
      FILL: begin
        // Base has its offset bits cleared, so OR-ing the word offset never carries.
        if (!issue_done) begin
          memory_enable  = 1'b1;
          memory_address = base_q | (ADDR_WIDTH'(issue_cnt) << 1);
          issue_en       = 1'b1;
        end
        if (memory_data_valid && !return_done) begin
          write_data_array = 1'b1;
          word_index       = return_cnt[IDX_BITS-1:0];
          return_en        = 1'b1;
          if (return_cnt == CNT_BITS'(WORDS_PER_BLOCK - 1)) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  assign fsm_busy = (state_q == FILL);

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: stimulus pushes expected issue/write
// events with their cycle stamps, a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic        write_tag_array;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_WIDTH(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .memory_enable     (memory_enable),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount++;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
  } addr_exp_t;

  typedef struct {
    int       cyc;
    logic [2:0] idx;
    logic     tag;
  } wr_exp_t;

  addr_exp_t addrQ[$];
  wr_exp_t   wrQ[$];
  addr_exp_t curAddr;
  wr_exp_t   curWr;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Monitor: every observed issue or write must match the head of its queue.
  always @(negedge clk) begin
    if (memory_enable) begin
      if (addrQ.size() == 0) begin
        checkOutput("spurious memory_enable", 32'(memory_enable), 32'd0);
      end else begin
        curAddr = addrQ.pop_front();
        checkOutput("issue cycle", 32'(cycleCount), 32'(curAddr.cyc));
        checkOutput("memory_address", 32'(memory_address), 32'(curAddr.addr));
      end
    end else begin
      checkOutput("idle memory_address", 32'(memory_address), 32'd0);
    end
    if (write_data_array) begin
      if (wrQ.size() == 0) begin
        checkOutput("spurious write_data_array", 32'(write_data_array), 32'd0);
      end else begin
        curWr = wrQ.pop_front();
        checkOutput("write cycle", 32'(cycleCount), 32'(curWr.cyc));
        checkOutput("word_index", 32'(word_index), 32'(curWr.idx));
        checkOutput("write_tag_array", 32'(write_tag_array), 32'(curWr.tag));
      end
    end else begin
      checkOutput("quiet tag/index", 32'({write_tag_array, word_index}), 32'd0);
    end
  end

  // One complete fill with LAT-cycle returns; words after gapAfter slip by gapLen.
  task automatic applyStimulus(input logic [15:0] addr, input int gapAfter, input int gapLen,
                               input bit holdMiss, input bit preArmed, input bit strayValid);
    int t;
    int retCyc[8];
    int lastRet;
    logic [15:0] base;
    bit isRet;
    if (!preArmed) begin
      @(posedge clk);
      #1;
    end
    miss_detected = 1'b1;
    miss_address  = addr;
    t    = cycleCount + 1;
    base = addr & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      addrQ.push_back('{cyc: t + i, addr: base + 16'(2 * i)});
      retCyc[i] = t + LAT + i + ((i > gapAfter) ? gapLen : 0);
      wrQ.push_back('{cyc: retCyc[i], idx: 3'(i), tag: (i == 7)});
    end
    lastRet = retCyc[7];
    for (int c = t; c <= lastRet + 1; c++) begin
      @(posedge clk);
      #1;
      miss_detected = holdMiss;
      isRet = 1'b0;
      for (int k = 0; k < 8; k++) if (retCyc[k] == c) isRet = 1'b1;
      memory_data_valid = isRet || (strayValid && c == lastRet + 1);
      @(negedge clk);
      checkOutput("fsm_busy", 32'(fsm_busy), 32'(c <= lastRet));
    end
    memory_data_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst_n             = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    #2;
    checkOutput("outputs in reset", 32'({fsm_busy, memory_enable, memory_address, write_data_array,
                                          word_index, write_tag_array}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("busy after reset", 32'(fsm_busy), 32'd0);

    $display("[TB] single fill 0x1236");
    applyStimulus(16'h1236, 8, 0, 1'b0, 1'b0, 1'b0);
    $display("[TB] top-of-memory block 0xFFFF");
    applyStimulus(16'hFFFF, 8, 0, 1'b0, 1'b0, 1'b0);
    $display("[TB] gapped returns");
    applyStimulus(16'h2048, 3, 3, 1'b0, 1'b0, 1'b0);
    $display("[TB] miss held through fill, stray valid in idle");
    applyStimulus(16'h3000, 8, 0, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h3106, 8, 0, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-fill after word 2");
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'h4444;
    t = cycleCount + 1;
    for (int i = 0; i < 7; i++) addrQ.push_back('{cyc: t + i, addr: 16'h4440 + 16'(2 * i)});
    for (int i = 0; i < 3; i++) wrQ.push_back('{cyc: t + LAT + i, idx: 3'(i), tag: 1'b0});
    for (int c = t; c <= t + 7; c++) begin
      @(posedge clk);
      #1;
      miss_detected     = 1'b0;
      memory_data_valid = (c >= t + LAT);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("outputs after async reset", 32'({fsm_busy, memory_enable, memory_address, write_data_array,
                                                   word_index, write_tag_array}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    memory_data_valid = 1'b0;
    @(negedge clk);
    checkOutput("busy after mid-fill reset", 32'(fsm_busy), 32'd0);
    applyStimulus(16'h5552, 8, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("issue events outstanding", 32'(addrQ.size()), 32'd0);
    checkOutput("write events outstanding", 32'(wrQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the L1 caches and the shared 16-bit byte-addressable main memory. On a cache miss it issues one read per word of the missing block to memory, streams returned words into the cache data array, and writes the tag once the block is complete. Memory is pipelined with fixed latency, so a new address is issued every cycle while earlier reads are in flight.

## Interface
Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block (power of two)
- ADDR_WIDTH, 16, byte address width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- miss_detected  in  1  cache reports a miss; sampled only in IDLE
- miss_address  in  ADDR_WIDTH  byte address of the missing access
- fsm_busy  out  1  high from the cycle after acceptance until the fill completes; stalls the pipeline
- memory_enable  out  1  read request to memory this cycle
- memory_address  out  ADDR_WIDTH  word-aligned byte address of the request
- memory_data_valid  in  1  memory returns one word this cycle
- write_data_array  out  1  write the current memory word into the cache data array
- word_index  out  log2(WORDS_PER_BLOCK)  block word slot for write_data_array
- write_tag_array  out  1  write tag and set valid for the block

## Operation
- States: IDLE, FILL.
- IDLE: all outputs 0. miss_detected=1 -> latch base = miss_address with low log2(WORDS_PER_BLOCK)+1 bits cleared; clear issue_cnt and return_cnt; go FILL.
- FILL, issue side: while issue_cnt < WORDS_PER_BLOCK, memory_enable=1, memory_address = base + 2*issue_cnt, issue_cnt increments. Then memory_enable=0, memory_address=0.
- FILL, return side: memory_data_valid=1 and return_cnt < WORDS_PER_BLOCK -> write_data_array=1, word_index=return_cnt, return_cnt increments.
- Completion: on the return for word_index = WORDS_PER_BLOCK-1, write_tag_array=1 in the same cycle; next state IDLE.
- Address arithmetic: base + 2*i never carries out of the block (offset bits cleared), so no wrap past the block; address 0xFFF0 block issues 0xFFF0..0xFFFE.
- memory_data_valid in IDLE ignored. Extra valids after return_cnt reaches WORDS_PER_BLOCK ignored.
- miss_detected while FILL ignored (cache holds it until busy drops); new miss accepted earliest the cycle after return to IDLE.
- Bit 0 of miss_address is don't-care.

## Timing
- Reset (rst_n=0, any time including mid-fill): state IDLE, counters 0, all outputs 0 immediately (asynchronous); in-flight memory returns after release are ignored.
- Miss sampled at edge T -> FILL from T; memory_enable high cycles T..T+WORDS_PER_BLOCK-1.
- write_data_array, word_index, write_tag_array are combinational on memory_data_valid and registered counters (zero added latency).
- fsm_busy = (state==FILL), registered; with memory latency L, last valid at T+WORDS_PER_BLOCK-1+L, fsm_busy low the following cycle.
- Controller is latency-agnostic; correct for any L>=1, including gaps in valid.

## Structure
- Package cache_pkg: state enum (IDLE, FILL), WORDS_PER_BLOCK, OFFSET_BITS = log2(WORDS_PER_BLOCK)+1 constants, shared with cache tag/data arrays.
- One sub-module: fill_counter (saturating up-counter with clear, enable, done flag), instantiated twice for issue_cnt and return_cnt.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 before next edge; after release, fsm_busy=0.
- Single fill, L=4: miss_address=0x1236 at T -> addresses 0x1230,0x1232,...,0x123E at T..T+7; write_data_array at T+4..T+11 with word_index 0..7; write_tag_array only at T+11; fsm_busy low at T+12.
- Top-of-memory block: miss_address=0xFFFF -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
- Gapped returns: valid deasserted for 3 cycles between words 3 and 4 -> word_index still 0..7 in order, write_tag_array with word 7 only.
- Miss during fill and stray valids: miss_detected held high through fill, plus valid in IDLE -> no second fill starts until busy drops, no data write in IDLE; second fill then starts the cycle after.
- Reset mid-fill after word 2 returned -> outputs 0, state IDLE, subsequent miss restarts at word_index 0.
